// File: rtl/ls_capture.sv
// Logic-slice sample-buffer writer: circular capture with pre-trigger window and
// single-channel edge trigger, frozen buffer read back one display column at a time.
module ls_capture #(
   parameter int N_CH  = 4,
   parameter int DEPTH = 960,
   parameter int AW    = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sample_en,
   input  logic [N_CH-1:0] din,
   input  logic            arm,
   input  logic            stop,
   input  logic [1:0]      trig_ch,
   input  logic            trig_rise,
   input  logic [AW-1:0]   pre_trig,
   input  logic [AW-1:0]   scan_n,
   output logic [N_CH-1:0] s_wave,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   trig_addr
);

   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);

   state_t state, state_n;

   logic [N_CH-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr, fill_cnt, post_cnt, pre_eff, post_len, pre_clamp;
   logic            prev, prev_valid, cur, edge_hit;
   logic            wr, take, start;
   logic [AW+1:0]   rd_sum, rd_1;
   logic [AW-1:0]   rd;
   logic            rd_ok;

   assign pre_clamp = (pre_trig > LAST) ? LAST : pre_trig;
   assign post_len  = LAST - pre_eff;
   assign cur       = din[trig_ch];
   // prev_valid keeps the first sample after arm from comparing against stale history
   assign edge_hit  = prev_valid && (trig_rise ? (!prev && cur) : (prev && !cur));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      wr      = 1'b0;
      take    = 1'b0;
      start   = 1'b0;
      if (stop) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  start   = 1'b1;
                  state_n = FILL;
               end
            end
            FILL: begin
               if (pre_eff == '0) begin
                  state_n = ARMED;
               end else if (sample_en) begin
                  wr = 1'b1;
                  if (fill_cnt + AW'(1) == pre_eff) state_n = ARMED;
               end
            end
            ARMED: begin
               if (sample_en) begin
                  wr = 1'b1;
                  if (edge_hit) begin
                     take    = 1'b1;
                     state_n = (post_len == '0) ? DONE : POST;
                  end
               end
            end
            POST: begin
               if (sample_en) begin
                  wr = 1'b1;
                  if (post_cnt + AW'(1) == post_len) state_n = DONE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Oldest-sample column maps to trig_addr - pre_eff; two folds cover the full sum range
   always_comb begin
      rd_sum = {2'b00, trig_addr} + DEPTH_X - {2'b00, pre_eff} + {2'b00, scan_n};
      rd_1   = (rd_sum >= DEPTH_X) ? rd_sum - DEPTH_X : rd_sum;
      rd     = (rd_1 >= DEPTH_X) ? AW'(rd_1 - DEPTH_X) : AW'(rd_1);
      rd_ok  = ({2'b00, scan_n} < DEPTH_X) && (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         fill_cnt   <= '0;
         post_cnt   <= '0;
         pre_eff    <= '0;
         prev       <= 1'b0;
         prev_valid <= 1'b0;
         trig_addr  <= '0;
         s_wave     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_n == FILL) || (state_n == ARMED) || (state_n == POST);
         done <= (state_n == DONE);
         if (start) begin
            wptr       <= '0;
            fill_cnt   <= '0;
            prev_valid <= 1'b0;
            pre_eff    <= pre_clamp;
         end else if (wr) begin
            wptr       <= (wptr == LAST) ? '0 : wptr + AW'(1);
            prev       <= cur;
            prev_valid <= 1'b1;
            if (state == FILL) fill_cnt <= fill_cnt + AW'(1);
            if (state == POST) post_cnt <= post_cnt + AW'(1);
         end
         if (take) begin
            trig_addr <= wptr;
            post_cnt  <= '0;
         end
         s_wave <= rd_ok ? mem[rd] : '0;
      end
   end

endmodule

// File: tb/tb_ls_capture.sv
// Directed bench for ls_capture: capture scenarios followed by table-driven
// readback of the frozen buffer.
module tb_ls_capture;

   logic       clk = 1'b0;
   logic       rst, sample_en, arm, stop, trig_rise;
   logic [3:0] din;
   logic [1:0] trig_ch;
   logic [9:0] pre_trig, scan_n;
   logic [3:0] s_wave;
   logic       busy, done;
   logic [9:0] trig_addr;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int         grp;
      logic [9:0] scan;
      logic [3:0] exp;
   } vec_t;
   vec_t vec[$];

   ls_capture #(.N_CH(4), .DEPTH(960), .AW(10)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .arm(arm), .stop(stop),
      .trig_ch(trig_ch), .trig_rise(trig_rise), .pre_trig(pre_trig), .scan_n(scan_n),
      .s_wave(s_wave), .busy(busy), .done(done), .trig_addr(trig_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic smp(input logic [3:0] d);
      din = d;
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic read_grp(input int g);
      foreach (vec[i]) begin
         if (vec[i].grp == g) begin
            scan_n = vec[i].scan;
            tick();
            chk($sformatf("read_g%0d_col%0d", g, vec[i].scan), int'(s_wave), int'(vec[i].exp));
         end
      end
   endtask

   initial begin
      logic [3:0] d;
      // basic capture: column c holds sample 50+c
      vec.push_back('{1, 10'd0,    4'd4});
      vec.push_back('{1, 10'd1,    4'd6});
      vec.push_back('{1, 10'd99,   4'ha});
      vec.push_back('{1, 10'd100,  4'hd});
      vec.push_back('{1, 10'd500,  4'hd});
      vec.push_back('{1, 10'd959,  4'd3});
      vec.push_back('{1, 10'd960,  4'd0});
      vec.push_back('{1, 10'd1023, 4'd0});
      // pre-trigger wrap: column 0 is sample 1500
      vec.push_back('{2, 10'd0,    4'd8});
      vec.push_back('{2, 10'd500,  4'd1});
      vec.push_back('{2, 10'd959,  4'd7});
      // pre_trig=0: column 0 is the trigger sample
      vec.push_back('{3, 10'd0,    4'd3});
      vec.push_back('{3, 10'd1,    4'd5});
      vec.push_back('{3, 10'd959,  4'd1});
      // clamped pre_trig: column 959 is the trigger sample
      vec.push_back('{4, 10'd0,    4'd2});
      vec.push_back('{4, 10'd1,    4'd4});
      vec.push_back('{4, 10'd959,  4'd1});
      vec.push_back('{4, 10'd960,  4'd0});
      // falling edge on channel 2
      vec.push_back('{5, 10'd0,    4'd5});
      vec.push_back('{5, 10'd2,    4'd5});
      vec.push_back('{5, 10'd3,    4'd0});
      vec.push_back('{5, 10'd4,    4'd1});
      vec.push_back('{5, 10'd958,  4'd1});

      rst = 1'b1; sample_en = 1'b0; arm = 1'b0; stop = 1'b0; din = '0;
      trig_ch = 2'd0; trig_rise = 1'b1; pre_trig = '0; scan_n = '0;
      tick(); tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_swave", s_wave, 0);
      chk("reset_trig_addr", trig_addr, 0);
      rst = 1'b0;

      // basic capture
      pre_trig = 10'd100;
      pulse_arm();
      for (int k = 0; k <= 1009; k++) begin
         d = {k[2:0], k >= 150};
         smp(d);
         if (k == 50)   chk("basic_busy_fill", busy, 1);
         if (k == 1008) chk("basic_done_early", done, 0);
      end
      chk("basic_done", done, 1);
      chk("basic_busy_off", busy, 0);
      chk("basic_trig_addr", trig_addr, 150);
      read_grp(1);

      // arm from DONE, then reset mid-POST
      pre_trig = 10'd2;
      pulse_arm();
      chk("arm_done_busy", busy, 1);
      chk("arm_done_done", done, 0);
      smp(4'd0); smp(4'd0); smp(4'd1); smp(4'd0);
      chk("post_trig_addr", trig_addr, 2);
      rst = 1'b1; sample_en = 1'b1; din = 4'd1;
      tick();
      rst = 1'b0; sample_en = 1'b0;
      chk("rstpost_busy", busy, 0);
      chk("rstpost_done", done, 0);
      chk("rstpost_swave", s_wave, 0);
      chk("rstpost_trig_addr", trig_addr, 0);
      chk("rstpost_wptr", int'(dut.wptr), 0);

      // pre-trigger wrap
      pre_trig = 10'd500;
      pulse_arm();
      for (int k = 0; k <= 2459; k++) begin
         d = {k[2:0], k >= 2000};
         smp(d);
         if (k == 2458) chk("wrap_done_early", done, 0);
      end
      chk("wrap_done", done, 1);
      chk("wrap_trig_addr", trig_addr, 80);
      read_grp(2);

      // pre_trig=0: leave prev=0 behind, then an edge on the first sample must not trigger
      pre_trig = 10'd0;
      pulse_arm(); tick();
      smp(4'd0);
      pulse_stop();
      pulse_arm(); tick();
      smp(4'd1);
      chk("pre0_first_no_trig", trig_addr, 80);
      chk("pre0_still_armed", busy, 1);
      pulse_stop();
      pulse_arm(); tick();
      smp(4'd0);
      for (int k = 1; k <= 960; k++) begin
         d = {k[2:0], 1'b1};
         smp(d);
         if (k == 1)   chk("pre0_trig_addr", trig_addr, 1);
         if (k == 959) chk("pre0_done_early", done, 0);
      end
      chk("pre0_done", done, 1);
      read_grp(3);

      // pre_trig clamps to DEPTH-1: done on the trigger sample itself
      pre_trig = 10'd1023;
      pulse_arm();
      for (int k = 0; k <= 1000; k++) begin
         d = {k[2:0], k >= 1000};
         smp(d);
         if (k == 999) chk("clamp_done_early", done, 0);
      end
      chk("clamp_done", done, 1);
      chk("clamp_trig_addr", trig_addr, 40);
      read_grp(4);

      // stop and arm together in DONE: stop wins
      arm = 1'b1; stop = 1'b1;
      tick();
      arm = 1'b0; stop = 1'b0;
      chk("stoparm_busy", busy, 0);
      chk("stoparm_done", done, 0);
      scan_n = 10'd0;
      tick();
      chk("idle_swave", s_wave, 0);

      // falling edge on ch2, ch0 toggling, sparse strobes, arm ignored in ARMED
      trig_ch = 2'd2; trig_rise = 1'b0; pre_trig = 10'd3;
      pulse_arm();
      for (int k = 0; k <= 10; k++) begin
         d = {1'b0, (k >= 4 && k < 10), 1'b0, k[0]};
         smp(d);
         tick();
         if (k == 6) pulse_arm();
         if (k == 9) chk("fall_no_false_trig", trig_addr, 40);
      end
      chk("fall_trig_addr", trig_addr, 10);
      chk("fall_busy_post", busy, 1);
      for (int k = 11; k <= 966; k++) begin
         d = {3'b000, k[0]};
         smp(d);
         if (k == 965) chk("fall_done_early", done, 0);
      end
      chk("fall_done", done, 1);
      read_grp(5);

      pulse_arm();
      chk("rearm_busy", busy, 1);
      chk("rearm_done", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
